// File: rtl/filter_ctl_pkg.sv
// Shared types for the filter control table loader and its consumers.
package filter_ctl_pkg;

  localparam int FILTER_CTL_W = 10;

  typedef struct packed {
    logic       en;
    logic [2:0] mode;
    logic [5:0] coeff;
  } filter_ctl_t;

  typedef enum logic {FILL, HOLD} ldr_state_e;

endpackage

// File: rtl/filter_ctl_sel.sv
// Combinational 2D entry select with zero-extended coeff; out-of-range selects give 0.
module filter_ctl_sel
  import filter_ctl_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 3,
  parameter int RW   = 1,
  parameter int CW   = 2
) (
  input  logic [ROWS*COLS*FILTER_CTL_W-1:0] tbl_i,
  input  logic [RW-1:0]                     row_i,
  input  logic [CW-1:0]                     col_i,
  output logic [31:0]                       coeff_o
);

  filter_ctl_t [ROWS-1:0][COLS-1:0] tbl;
  assign tbl = tbl_i;

  // en/mode fields are not observed on this path
  logic unused_tbl;
  assign unused_tbl = ^tbl_i;

  // decode every legal (row,col); anything else falls through to zero
  always_comb begin
    coeff_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (row_i == RW'(r) && col_i == CW'(c)) coeff_o = {26'b0, tbl[r][c].coeff};
      end
    end
  end

endmodule

// File: rtl/filter_ctl_table_loader.sv
// Collects filter_ctl_t entries one per beat into a ROWS x COLS table and holds it
// until downstream takes it. Optional FILTER_CTL_PARITY_EN drops bad-parity beats
// and counts them in err_cnt.
module filter_ctl_table_loader
  import filter_ctl_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [FILTER_CTL_W-1:0]           wr_data,
  output logic                              tbl_valid,
  input  logic                              tbl_ready,
  output logic [ROWS*COLS*FILTER_CTL_W-1:0] tbl_data,
  input  logic [(ROWS>1?$clog2(ROWS):1)-1:0] sel_row,
  input  logic [(COLS>1?$clog2(COLS):1)-1:0] sel_col,
  output logic [31:0]                       o
`ifdef FILTER_CTL_PARITY_EN
  ,
  input  logic                              wr_par,
  output logic [7:0]                        err_cnt
`endif
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  ldr_state_e              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  filter_ctl_t [N-1:0]     tbl_q, tbl_d;
  logic [31:0]             o_q, sel_val;
  logic                    acc, good;

  // flat entry idx is the same storage as tbl[idx/COLS][idx%COLS]
  assign tbl_data  = tbl_q;
  assign wr_ready  = (state_q == FILL);
  assign tbl_valid = (state_q == HOLD);
  assign acc       = wr_valid && wr_ready;
  assign o         = o_q;

`ifdef FILTER_CTL_PARITY_EN
  logic [7:0] err_q;
  assign good    = ~^{wr_data, wr_par};
  assign err_cnt = err_q;

  // saturating count of consumed-but-dropped beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_q <= '0;
    else if (acc && !good && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
`else
  assign good = 1'b1;
`endif

  // fill/hold sequencing; a dropped beat neither writes nor advances idx
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tbl_d   = tbl_q;
    case (state_q)
      FILL: begin
        if (acc && good) begin
          tbl_d[idx_q] = filter_ctl_t'(wr_data);
          if (idx_q == IW'(N-1)) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      HOLD: if (tbl_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // state, index and table storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tbl_q   <= tbl_d;
    end
  end

  filter_ctl_sel #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_sel (
    .tbl_i   (tbl_q),
    .row_i   (sel_row),
    .col_i   (sel_col),
    .coeff_o (sel_val)
  );

  // registered observation port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_q <= '0;
    else     o_q <= sel_val;
  end

endmodule
